// File: rtl/sound_sequencer_if.sv
// Link from the sequencer to the square-wave sound generator: one-shot
// 9-bit load strobe/data plus the start pulse.
interface sound_sequencer_if;
    logic       snd_data_tx;
    logic [8:0] snd_data;
    logic       snd_enable;

    modport master (output snd_data_tx, output snd_data, output snd_enable);
    modport slave  (input  snd_data_tx, input  snd_data, input  snd_enable);
endinterface

// File: rtl/sound_sequencer.sv
// Note-list player: buffers packed {tone, dur} words in a FIFO and plays them
// one by one on the sound generator, timing each note plus a silent gap.
module sound_sequencer #(
    parameter int DEPTH     = 8,
    parameter int DUR_SHIFT = 21,
    parameter int GAP       = 16
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   wr_en,
    input  logic [15:0]            wr_data,
    input  logic                   play,
    input  logic                   flush,
    output logic                   full,
    output logic [$clog2(DEPTH):0] count,
    output logic                   overflow,
    output logic                   busy,
    sound_sequencer_if.master      snd
);
    localparam int AW = $clog2(DEPTH);
    localparam int TW = 8 + DUR_SHIFT;
    localparam logic [AW:0] DEPTH_CNT = (AW+1)'(DEPTH);

    typedef enum logic [2:0] {
        ST_IDLE, ST_TONE, ST_DUR, ST_START, ST_WAIT, ST_GAP
    } state_t;

    state_t        state, state_nxt;
    logic [15:0]   mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [15:0]   head;
    logic [7:0]    head_tone, head_dur;
    logic [7:0]    note_tone, note_dur;
    logic [TW-1:0] timer;
    logic          pop, wr_ok;
    logic          tx_nxt, en_nxt;
    logic [8:0]    data_nxt;

    assign head      = mem[rd_ptr];
    assign head_tone = head[15:8];
    assign head_dur  = head[7:0];
    assign full      = (count == DEPTH_CNT);
    // Fullness is judged on the pre-pop occupancy; flush swallows a same-cycle write.
    assign wr_ok     = wr_en && !full && !flush;
    assign busy      = (state != ST_IDLE) || (count != '0);

    // FIFO storage and the popped note are plain data, no reset needed.
    always_ff @(posedge clk) begin
        if (wr_ok)
            mem[wr_ptr] <= wr_data;
        if (pop) begin
            note_tone <= head_tone;
            note_dur  <= head_dur;
        end
    end

    // FIFO pointers, occupancy and the sticky overflow flag.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else if (flush) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (wr_ok)
                wr_ptr <= wr_ptr + AW'(1);
            if (pop)
                rd_ptr <= rd_ptr + AW'(1);
            count <= count + (AW+1)'(wr_ok) - (AW+1)'(pop);
            if (wr_en && full)
                overflow <= 1'b1;
        end
    end

    // Shared note/gap timer: loaded with the note length at pop, counts down in
    // WAIT, then reloaded with the gap length for GAP.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            timer <= '0;
        else if (pop)
            timer <= TW'(head_dur) << DUR_SHIFT;
        else if (state == ST_WAIT)
            timer <= (timer == TW'(1)) ? TW'(GAP) : timer - TW'(1);
        else if (state == ST_GAP)
            timer <= timer - TW'(1);
    end

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            state <= ST_IDLE;
        else
            state <= state_nxt;
    end

    // Next state, pop decision and the generator outputs for the next cycle.
    always_comb begin
        state_nxt = state;
        pop       = 1'b0;
        tx_nxt    = 1'b0;
        en_nxt    = 1'b0;
        data_nxt  = 9'h000;
        if (flush) begin
            state_nxt = ST_IDLE;
            // A sounding note is cut by loading a zero duration, which stops the generator.
            if (state == ST_TONE || state == ST_DUR || state == ST_START ||
                (state == ST_WAIT && note_tone != 8'h00))
                tx_nxt = 1'b1;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (play && count != '0) begin
                        pop = 1'b1;
                        if (head_dur == 8'h00) begin
                            state_nxt = ST_IDLE;
                        end else if (head_tone == 8'h00) begin
                            state_nxt = ST_WAIT;
                        end else begin
                            state_nxt = ST_TONE;
                            tx_nxt    = 1'b1;
                            data_nxt  = {1'b1, head_tone};
                        end
                    end
                end
                ST_TONE: begin
                    state_nxt = ST_DUR;
                    tx_nxt    = 1'b1;
                    data_nxt  = {1'b0, note_dur};
                end
                ST_DUR: begin
                    state_nxt = ST_START;
                    en_nxt    = 1'b1;
                end
                ST_START: state_nxt = ST_WAIT;
                ST_WAIT:  if (timer == TW'(1)) state_nxt = ST_GAP;
                ST_GAP:   if (timer == TW'(1)) state_nxt = ST_IDLE;
                default:  state_nxt = ST_IDLE;
            endcase
        end
    end

    // Registered generator interface.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            snd.snd_data_tx <= 1'b0;
            snd.snd_data    <= 9'h000;
            snd.snd_enable  <= 1'b0;
        end else begin
            snd.snd_data_tx <= tx_nxt;
            snd.snd_data    <= data_nxt;
            snd.snd_enable  <= en_nxt;
        end
    end
endmodule

// File: tb/tb_sound_sequencer.sv
// Bench for sound_sequencer: directed note sequences checked against a
// note-schedule model every cycle, plus literal expectations per scenario.
module tb_sound_sequencer;
    localparam int DEPTH     = 8;
    localparam int DUR_SHIFT = 2;
    localparam int GAP       = 2;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        wr_en;
    logic [15:0] wr_data;
    logic        play;
    logic        flush;
    logic        full;
    logic [3:0]  count;
    logic        overflow;
    logic        busy;

    sound_sequencer_if snd_bus ();

    sound_sequencer #(.DEPTH(DEPTH), .DUR_SHIFT(DUR_SHIFT), .GAP(GAP)) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .wr_en    (wr_en),
        .wr_data  (wr_data),
        .play     (play),
        .flush    (flush),
        .full     (full),
        .count    (count),
        .overflow (overflow),
        .busy     (busy),
        .snd      (snd_bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    logic chk_en = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Model: each popped note expands into a list of per-cycle output entries.
    typedef struct packed {
        logic       tx;
        logic [8:0] data;
        logic       en;
        logic       snd;   // cycle belongs to an audible note before its gap
    } ent_t;

    ent_t        sched[$];
    ent_t        cur;
    logic        m_busy;
    logic [15:0] mq[$];
    logic        m_ovf;

    always @(posedge clk or negedge reset_n) begin : model
        int          n0;
        int          len;
        logic [15:0] note;
        ent_t        e;
        if (!reset_n) begin
            sched.delete();
            mq.delete();
            cur    = '0;
            m_busy = 1'b0;
            m_ovf  = 1'b0;
        end else if (flush) begin
            e      = '0;
            e.tx   = m_busy && cur.snd;
            sched.delete();
            mq.delete();
            m_ovf  = 1'b0;
            cur    = e;
            m_busy = 1'b0;
        end else begin
            n0 = mq.size();
            if (!m_busy && play && n0 > 0) begin
                note = mq.pop_front();
                len  = int'(note[7:0]) << DUR_SHIFT;
                if (note[7:0] != 8'h00) begin
                    if (note[15:8] != 8'h00) begin
                        e = '0; e.tx = 1'b1; e.data = {1'b1, note[15:8]}; e.snd = 1'b1; sched.push_back(e);
                        e = '0; e.tx = 1'b1; e.data = {1'b0, note[7:0]};  e.snd = 1'b1; sched.push_back(e);
                        e = '0; e.en = 1'b1; e.snd = 1'b1; sched.push_back(e);
                    end
                    for (int i = 0; i < len; i++) begin
                        e = '0; e.snd = (note[15:8] != 8'h00); sched.push_back(e);
                    end
                    for (int i = 0; i < GAP; i++) begin
                        e = '0; sched.push_back(e);
                    end
                end
            end
            if (wr_en) begin
                if (n0 == DEPTH) m_ovf = 1'b1;
                else             mq.push_back(wr_data);
            end
            if (sched.size() > 0) begin
                cur    = sched.pop_front();
                m_busy = 1'b1;
            end else begin
                cur    = '0;
                m_busy = 1'b0;
            end
        end
    end

    // Per-cycle comparison of every output against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            check("m_tx",     32'(snd_bus.snd_data_tx), 32'(cur.tx));
            check("m_enable", 32'(snd_bus.snd_enable),  32'(cur.en));
            if (cur.tx)
                check("m_data", 32'(snd_bus.snd_data), 32'(cur.data));
            check("m_count",    32'(count),    32'(mq.size()));
            check("m_full",     32'(full),     32'(mq.size() == DEPTH));
            check("m_overflow", 32'(overflow), 32'(m_ovf));
            check("m_busy",     32'(busy),     32'(m_busy || mq.size() != 0));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write_note(input logic [15:0] d);
        wr_en   = 1'b1;
        wr_data = d;
        tick();
        wr_en   = 1'b0;
    endtask

    task automatic wait_tone(output logic [8:0] d, output logic found);
        d     = '0;
        found = 1'b0;
        for (int k = 0; k < 60 && !found; k++) begin
            tick();
            if (snd_bus.snd_data_tx && snd_bus.snd_data[8]) begin
                d     = snd_bus.snd_data;
                found = 1'b1;
            end
        end
    endtask

    task automatic wait_idle();
        for (int k = 0; k < 200 && busy; k++)
            tick();
        check("idle_reached", 32'(busy), 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [8:0] d;
        logic       found;
        int         n;
        logic       saw_tx, saw_en;

        reset_n = 1'b0; wr_en = 1'b0; wr_data = '0; play = 1'b0; flush = 1'b0;
        repeat (2) @(posedge clk);
        chk_en = 1'b1;
        #1;
        check("rst_tx",    32'(snd_bus.snd_data_tx), 32'd0);
        check("rst_data",  32'(snd_bus.snd_data),    32'h000);
        check("rst_en",    32'(snd_bus.snd_enable),  32'd0);
        check("rst_count", 32'(count),    32'd0);
        check("rst_full",  32'(full),     32'd0);
        check("rst_ovf",   32'(overflow), 32'd0);
        check("rst_busy",  32'(busy),     32'd0);
        reset_n = 1'b1;
        tick();

        // 1: plain note 0x10 for 3<<2 cycles
        play = 1'b1;
        write_note(16'h1003);
        check("t1_count", 32'(count), 32'd1);
        tick();
        check("t1_tone_tx", 32'(snd_bus.snd_data_tx), 32'd1);
        check("t1_tone",    32'(snd_bus.snd_data),    32'h110);
        tick();
        check("t1_dur",     32'(snd_bus.snd_data),    32'h003);
        tick();
        check("t1_enable",  32'(snd_bus.snd_enable),  32'd1);
        n = 0;
        for (int k = 0; k < 100; k++) begin
            tick();
            if (!busy) break;
            n++;
        end
        check("t1_wait_gap_len", 32'(n), 32'd14);

        // 2: rest note, busy for 1 + 16 + 2 cycles, no generator activity
        write_note(16'h0004);
        n = 0; saw_tx = 1'b0; saw_en = 1'b0;
        while (busy && n < 100) begin
            n++;
            saw_tx |= snd_bus.snd_data_tx;
            saw_en |= snd_bus.snd_enable;
            tick();
        end
        check("t2_busy_len", 32'(n), 32'd19);
        check("t2_no_tx",    32'(saw_tx), 32'd0);
        check("t2_no_en",    32'(saw_en), 32'd0);

        // 3: zero-duration entry discarded, next note follows immediately
        write_note(16'h2000);
        write_note(16'h2101);
        tick();
        check("t3_tx",   32'(snd_bus.snd_data_tx), 32'd1);
        check("t3_tone", 32'(snd_bus.snd_data),    32'h121);
        wait_idle();

        // 4: fill while paused, ninth write overflows, then play in order
        play = 1'b0;
        for (int i = 0; i < 9; i++)
            write_note({8'h40 + 8'(i), 8'h01});
        check("t4_full",  32'(full),     32'd1);
        check("t4_count", 32'(count),    32'd8);
        check("t4_ovf",   32'(overflow), 32'd1);
        play = 1'b1;
        for (int i = 0; i < 8; i++) begin
            wait_tone(d, found);
            check("t4_tone_seen", 32'(found), 32'd1);
            check("t4_order",     32'(d),     32'({1'b1, 8'h40 + 8'(i)}));
        end
        wait_idle();
        check("t4_ovf_sticky", 32'(overflow), 32'd1);

        // 5: flush during WAIT with three notes queued and a same-cycle write
        write_note(16'h30FF);
        write_note(16'h3101);
        write_note(16'h3201);
        write_note(16'h3301);
        repeat (12) tick();
        check("t5_queued", 32'(count), 32'd3);
        flush = 1'b1; wr_en = 1'b1; wr_data = 16'h3401;
        tick();
        flush = 1'b0; wr_en = 1'b0;
        check("t5_kill_tx",   32'(snd_bus.snd_data_tx), 32'd1);
        check("t5_kill_data", 32'(snd_bus.snd_data),    32'h000);
        check("t5_kill_en",   32'(snd_bus.snd_enable),  32'd0);
        check("t5_count",     32'(count),    32'd0);
        check("t5_ovf",       32'(overflow), 32'd0);
        check("t5_busy",      32'(busy),     32'd0);
        saw_tx = 1'b0; saw_en = 1'b0;
        for (int k = 0; k < 20; k++) begin
            tick();
            saw_tx |= snd_bus.snd_data_tx;
            saw_en |= snd_bus.snd_enable;
        end
        check("t5_quiet_tx", 32'(saw_tx), 32'd0);
        check("t5_quiet_en", 32'(saw_en), 32'd0);

        // 6: asynchronous reset while the duration word is out
        write_note(16'h5102);
        wait_tone(d, found);
        check("t6_tone", 32'(d), 32'h151);
        tick();
        check("t6_in_dur", 32'(snd_bus.snd_data), 32'h002);
        #2;
        reset_n = 1'b0;
        #1;
        check("t6_rst_tx",    32'(snd_bus.snd_data_tx), 32'd0);
        check("t6_rst_data",  32'(snd_bus.snd_data),    32'h000);
        check("t6_rst_en",    32'(snd_bus.snd_enable),  32'd0);
        check("t6_rst_busy",  32'(busy),     32'd0);
        check("t6_rst_count", 32'(count),    32'd0);
        check("t6_rst_full",  32'(full),     32'd0);
        check("t6_rst_ovf",   32'(overflow), 32'd0);
        repeat (3) tick();
        reset_n = 1'b1;
        saw_tx = 1'b0; n = 0;
        for (int k = 0; k < 10; k++) begin
            tick();
            saw_tx |= snd_bus.snd_data_tx | snd_bus.snd_enable;
            if (busy) n++;
        end
        check("t6_idle_tx",   32'(saw_tx), 32'd0);
        check("t6_idle_busy", 32'(n),      32'd0);
        write_note(16'h6201);
        wait_tone(d, found);
        check("t6_after_tone", 32'(d), 32'h162);
        wait_idle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/sound_sequencer.md
# sound_sequencer

Note-list player that sits directly upstream of the square-wave `sound` generator. The CPU writes packed notes, each a tone plus a duration, into an internal FIFO. The sequencer pops them one at a time. For each note it drives the generator's one-shot 9-bit load interface (tone word, then duration word) and then its rising-edge `enable`. It then times the note itself, because the generator has no "done" output.

## Interface
Parameters:
- `DEPTH`, 8: FIFO entries; power of two.
- `DUR_SHIFT`, 21: note length is `dur << DUR_SHIFT` clocks. Matches the generator's duration compare.
- `GAP`, 16: silent clocks after each note, minimum 2. Guarantees a low phase on `snd_enable` between notes.

Ports:
- `clk`, in, 1: system clock.
- `reset_n`, in, 1: asynchronous, active-low reset.
- `wr_en`, in, 1: one-cycle write strobe.
- `wr_data`, in, 16: note word `{tone[7:0], dur[7:0]}`.
- `play`, in, 1: level; while low, no new note is popped.
- `flush`, in, 1: one-cycle; aborts the current note and empties the FIFO.
- `full`, out, 1: FIFO full.
- `count`, out, $clog2(DEPTH)+1: FIFO occupancy.
- `overflow`, out, 1: sticky; a write was dropped.
- `busy`, out, 1: high when state ≠ IDLE or `count` ≠ 0.
- `snd_data_tx`, out, 1: one-shot load strobe to the generator.
- `snd_data`, out, 9: bit 8 = 1 for tone, 0 for duration.
- `snd_enable`, out, 1: start pulse to the generator.

## Operation
- **FIFO**
  - A write is accepted when `wr_en` is high and `full` is low, sampled before that cycle's pop.
  - A write while full is dropped and sets `overflow`, even if a pop happens in the same cycle.
  - `flush` has priority over a same-cycle write: the write is dropped and does not set `overflow`.
- **State machine.** States are IDLE, TONE, DUR, START, WAIT, GAP.
  - **IDLE:** if `play` is high and `count` > 0, pop the head into the note register.
    - `dur` == 0: the entry is discarded and the machine stays in IDLE.
    - `tone` == 0 (rest): go to WAIT.
    - Otherwise: go to TONE.
  - **TONE:** `snd_data_tx` = 1, `snd_data` = {1, tone}. Go to DUR.
  - **DUR:** `snd_data_tx` = 1, `snd_data` = {0, dur}. Go to START.
  - **START:** `snd_enable` = 1 for exactly this cycle. Go to WAIT.
  - **WAIT:** the wait counter (width 8+DUR_SHIFT) loads `dur << DUR_SHIFT` on entry. It decrements once per cycle. WAIT lasts exactly `dur << DUR_SHIFT` cycles, then the machine goes to GAP.
  - **GAP:** lasts exactly `GAP` cycles, then the machine goes to IDLE.
- `play` going low does not affect a note already popped; it only blocks the next pop.
- **Flush:**
  - Clears the FIFO pointers, `count` and `overflow`, and forces the machine to IDLE on the next cycle.
  - If the state was TONE, DUR, START or WAIT with a non-rest note, the sequencer issues exactly one `snd_data_tx` with `snd_data` = {0, 8'h00` in the cycle after `flush`. This silences the generator by clearing its run flag.
  - `snd_enable` is low in that cycle.
- All `snd_*` outputs are registered. Outside the cycles listed above, `snd_data_tx` and `snd_enable` are 0.

## Timing
- **Reset values:** state IDLE; FIFO empty; `count` = 0; `full` = 0; `overflow` = 0; `busy` = 0; `snd_data_tx` = 0; `snd_data` = 9'h000; `snd_enable` = 0.
- **Reset mid-note:** outputs drop immediately. The generator is not explicitly silenced; its note runs out on its own.
- **Per-note cycle sequence,** with the pop at cycle T:
  - T+1: tone word on `snd_data`.
  - T+2: duration word on `snd_data`.
  - T+3: `snd_enable` high.
  - T+4 to T+3+(dur<<DUR_SHIFT): WAIT.
  - Next `GAP` cycles: GAP.
  - Following cycle: IDLE; the next pop is possible in that same cycle.
- **Rest note:** WAIT begins at T+1. There is no `snd_data_tx` and no `snd_enable`.
- **Latency:** a write to an empty FIFO in cycle W (with `play` high and the machine in IDLE) is popped in cycle W+1.
- **Status timing:** `count` and `full` update in the cycle after the write or pop. A simultaneous write and pop leaves `count` unchanged.

## Test plan
Bench settings: DUR_SHIFT=2, GAP=2.

1. Write 16'h1003 with `play`=1. Required response:
   - T+1: tone word 9'h110.
   - T+2: duration word 9'h003.
   - T+3: `snd_enable` high.
   - WAIT lasts 12 cycles, then 2 GAP cycles, then IDLE.
   - `busy` drops when the machine returns to IDLE.
2. Write 16'h0004 (rest). Required response: no `snd_data_tx` and no `snd_enable`; `busy` stays high for 1+16+2 cycles.
3. Write 16'h2000, then 16'h2101. Required response: the first entry is discarded silently, and the second note's tone word 9'h121 appears 2 cycles after the first pop.
4. With `play`=0, do 9 writes into an 8-deep FIFO. Required response: `full`=1, `count`=8, `overflow`=1. Raising `play` plays the first 8 notes in write order.
5. Assert `flush` during WAIT of note 16'h30FF with 3 more notes queued. Required response:
   - Next cycle: one `snd_data_tx` with `snd_data`=9'h000.
   - `count`=0, `overflow`=0, state IDLE.
   - No further `snd_enable`.
6. Assert `reset_n` low mid-DUR, asynchronously. Required response: all outputs reach their reset values before the next clock edge; after release, the sequencer stays idle until a new write.
